decode_ctrl_stage: RTL

Registered instruction-decode stage for the pipelined RV32 core. Generates the full per-instruction control bundle (branch type, immediate select, ALU control, memory read/write control, writeback select), holds it in an ID/EX pipeline register with a valid/ready handshake, and stalls on load-use and multi-cycle multiply/divide hazards. It sits between the IF/ID register and the execute stage. It adds optional M-extension decode and illegal-instruction flagging.

---
 rtl/decode_ctrl_stage.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) decode stage: builds the control bundle and holds it in the ID/EX register.
// Stalls on load-use and on in-flight multi-cycle mul/div.
module decode_ctrl_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HAS_MUL     = 1,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_use,
    output logic            out_rs2_use,
    output logic [2:0]      out_br_type,
    output logic            out_jal,
    output logic            out_jalr,
    output logic [3:0]      out_imm_sel,
    output logic            out_alu_a_sel,
    output logic            out_alu_b_sel,
    output logic [3:0]      out_alu_ctrl,
    output logic [2:0]      out_mem_rd_ctrl,
    output logic [1:0]      out_mem_wr_ctrl,
    output logic            out_mem_rw,
    output logic            out_reg_write,
    output logic            out_mem2reg,
    output logic            out_is_md,
    output logic [2:0]      out_md_op,
    output logic            out_illegal
);
    localparam logic [6:0] OpReg = 7'b0110011, OpImm = 7'b0010011, OpLoad = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011, OpBranch = 7'b1100011, OpJalr = 7'b1100111;
    localparam logic [6:0] OpJal = 7'b1101111, OpLui = 7'b0110111, OpAuipc = 7'b0010111;

    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4, AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7;
    localparam logic [3:0] AluOr = 4'd8, AluAnd = 4'd9, AluAp4 = 4'd10, AluOutB = 4'd11;
    localparam logic [3:0] ImmI = 4'd1, ImmS = 4'd2, ImmB = 4'd3, ImmJ = 4'd4, ImmU = 4'd5;
    localparam logic [2:0] MemLb = 3'd1, MemLbu = 3'd2, MemLh = 3'd3, MemLhu = 3'd4, MemLw = 3'd5;
    localparam logic [1:0] MemSb = 2'd1, MemSh = 2'd2, MemSw = 2'd3;

    localparam int unsigned CntW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MUL_LATENCY - 1);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_use;
        logic       rs2_use;
        logic [2:0] br_type;
        logic       jal;
        logic       jalr;
        logic [3:0] imm_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [3:0] alu_ctrl;
        logic [2:0] mem_rd_ctrl;
        logic [1:0] mem_wr_ctrl;
        logic       mem_rw;
        logic       reg_write;
        logic       mem2reg;
        logic       is_md;
        logic [2:0] md_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t           dec, bundle_d, bundle_q;
    logic            valid_d, valid_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            ill, hazard, md_busy, accept;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    always_comb begin
        dec = '0;
        ill = 1'b0;
        case (opcode)
            OpReg: begin
                dec.rs1_use   = 1'b1;
                dec.rs2_use   = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 1'b1;
                dec.reg_write = 1'b1;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000: dec.alu_ctrl = AluAdd;
                        3'b001: dec.alu_ctrl = AluSll;
                        3'b010: dec.alu_ctrl = AluSlt;
                        3'b011: dec.alu_ctrl = AluSltu;
                        3'b100: dec.alu_ctrl = AluXor;
                        3'b101: dec.alu_ctrl = AluSrl;
                        3'b110: dec.alu_ctrl = AluOr;
                        3'b111: dec.alu_ctrl = AluAnd;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec.alu_ctrl = AluSub;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    dec.alu_ctrl = AluSra;
                end else if (funct7 == 7'h01 && HAS_MUL != 0) begin
                    dec.is_md    = 1'b1;
                    dec.md_op    = funct3;
                    dec.alu_ctrl = AluAdd;
                end else begin
                    ill = 1'b1;
                end
            end
            OpImm: begin
                dec.rs1_use   = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.imm_sel   = ImmI;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000: dec.alu_ctrl = AluAdd;
                    3'b010: dec.alu_ctrl = AluSlt;
                    3'b011: dec.alu_ctrl = AluSltu;
                    3'b100: dec.alu_ctrl = AluXor;
                    3'b110: dec.alu_ctrl = AluOr;
                    3'b111: dec.alu_ctrl = AluAnd;
                    3'b001: if (funct7 == 7'h00) dec.alu_ctrl = AluSll; else ill = 1'b1;
                    3'b101: begin
                        if (funct7 == 7'h00) dec.alu_ctrl = AluSrl;
                        else if (funct7 == 7'h20) dec.alu_ctrl = AluSra;
                        else ill = 1'b1;
                    end
                endcase
            end
            OpLoad: begin
                dec.rs1_use   = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.imm_sel   = ImmI;
                dec.reg_write = 1'b1;
                dec.mem2reg   = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_rd_ctrl = MemLb;
                    3'b001:  dec.mem_rd_ctrl = MemLh;
                    3'b010:  dec.mem_rd_ctrl = MemLw;
                    3'b100:  dec.mem_rd_ctrl = MemLbu;
                    3'b101:  dec.mem_rd_ctrl = MemLhu;
                    default: ill = 1'b1;
                endcase
            end
            OpStore: begin
                dec.rs1_use   = 1'b1;
                dec.rs2_use   = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.imm_sel   = ImmS;
                dec.mem_rw    = 1'b1;
                case (funct3)
                    3'b000:  dec.mem_wr_ctrl = MemSb;
                    3'b001:  dec.mem_wr_ctrl = MemSh;
                    3'b010:  dec.mem_wr_ctrl = MemSw;
                    default: ill = 1'b1;
                endcase
            end
            OpBranch: begin
                dec.rs1_use   = 1'b1;
                dec.rs2_use   = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 1'b1;
                dec.imm_sel   = ImmB;
                dec.alu_ctrl  = AluSub;
                case (funct3)
                    3'b000:  dec.br_type = 3'd1;
                    3'b001:  dec.br_type = 3'd2;
                    3'b100:  dec.br_type = 3'd3;
                    3'b101:  dec.br_type = 3'd4;
                    3'b110:  dec.br_type = 3'd5;
                    3'b111:  dec.br_type = 3'd6;
                    default: ill = 1'b1;
                endcase
            end
            OpJalr: begin
                dec.rs1_use   = 1'b1;
                dec.jalr      = 1'b1;
                dec.imm_sel   = ImmI;
                dec.alu_ctrl  = AluAp4;
                dec.reg_write = 1'b1;
                if (funct3 != 3'b000) ill = 1'b1;
            end
            OpJal: begin
                dec.jal       = 1'b1;
                dec.imm_sel   = ImmJ;
                dec.alu_ctrl  = AluAp4;
                dec.reg_write = 1'b1;
            end
            OpLui: begin
                dec.imm_sel   = ImmU;
                dec.alu_ctrl  = AluOutB;
                dec.reg_write = 1'b1;
            end
            OpAuipc: begin
                dec.imm_sel   = ImmU;
                dec.alu_ctrl  = AluAdd;
                dec.reg_write = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // An illegal encoding carries no side effects downstream, only the flag.
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        dec.rd  = in_inst[11:7];
    end

    assign hazard = valid_q & bundle_q.mem2reg & (bundle_q.rd != 5'd0) &
                    ((dec.rs1_use & (dec.rs1 == bundle_q.rd)) |
                     (dec.rs2_use & (dec.rs2 == bundle_q.rd)));
    assign md_busy  = (cnt_q != '0);
    assign in_ready = !rst & !flush & !hazard & !md_busy & (!valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        pc_d     = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            pc_d     = in_pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // The md counter ignores flush: the consumed mul/div keeps running in execute.
        if (valid_q & out_ready & bundle_q.is_md) cnt_d = CntLoad;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_rs1         = bundle_q.rs1;
    assign out_rs2         = bundle_q.rs2;
    assign out_rd          = bundle_q.rd;
    assign out_rs1_use     = bundle_q.rs1_use;
    assign out_rs2_use     = bundle_q.rs2_use;
    assign out_br_type     = bundle_q.br_type;
    assign out_jal         = bundle_q.jal;
    assign out_jalr        = bundle_q.jalr;
    assign out_imm_sel     = bundle_q.imm_sel;
    assign out_alu_a_sel   = bundle_q.alu_a_sel;
    assign out_alu_b_sel   = bundle_q.alu_b_sel;
    assign out_alu_ctrl    = bundle_q.alu_ctrl;
    assign out_mem_rd_ctrl = bundle_q.mem_rd_ctrl;
    assign out_mem_wr_ctrl = bundle_q.mem_wr_ctrl;
    assign out_mem_rw      = bundle_q.mem_rw;
    assign out_reg_write   = bundle_q.reg_write;
    assign out_mem2reg     = bundle_q.mem2reg;
    assign out_is_md       = bundle_q.is_md;
    assign out_md_op       = bundle_q.md_op;
    assign out_illegal     = bundle_q.illegal;
endmodule
